// File: rtl/modem_pkg.sv
// Shared modem definitions: mode encoding (common with the modulator), sample format
// and receive FSM states.
package modem_pkg;

    localparam int SAMPLE_W = 7;
    localparam int MIDSCALE = 64;

    typedef enum logic [1:0] {
        MODE_ASK   = 2'b00,
        MODE_FSK   = 2'b01,
        MODE_BPSK  = 2'b10,
        MODE_SLICE = 2'b11
    } mode_t;

    typedef enum logic {
        RX_IDLE = 1'b0,
        RX_RUN  = 1'b1
    } rx_state_t;

endpackage

// File: rtl/modem_byte_asm.sv
// Packs recovered bits MSB-first into bytes and strobes byte_valid on every eighth bit.
module modem_byte_asm (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       shift,
    input  logic       bit_in,
    output logic [7:0] byte_out,
    output logic       byte_valid
);

    logic [6:0] sreg;
    logic [2:0] bcnt;

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg       <= '0;
            bcnt       <= '0;
            byte_out   <= '0;
            byte_valid <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            if (clear) begin
                sreg <= '0;
                bcnt <= '0;
            end else if (shift) begin
                sreg <= {sreg[5:0], bit_in};
                bcnt <= bcnt + 3'd1;
                if (bcnt == 3'd7) begin
                    byte_out   <= {sreg, bit_in};
                    byte_valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/modem_rx_demod.sv
// Multimode receive demodulator (ASK / FSK / BPSK / majority slicer), one bit per symbol.
// Optional byte assembler compiled in with `define MODEM_RX_BYTE_EN.
module modem_rx_demod
    import modem_pkg::*;
#(
    parameter int SPS      = 16,
    parameter int CAR_PER  = 8,
    parameter int ASK_THR  = 256,
    parameter int FSK_XTHR = 6
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [1:0]          sel,
    input  logic                en,
    input  logic [SAMPLE_W-1:0] sample_in,
    input  logic                sample_valid,
    output logic                bit_out,
    output logic                bit_valid,
    output logic [7:0]          byte_out,
    output logic                byte_valid,
    output logic                busy
);

    localparam int ACC_W = $clog2(64 * SPS) + 2;
    localparam int CNT_W = $clog2(SPS);
    localparam int XC_W  = $clog2(SPS) + 1;
    localparam int PH_W  = $clog2(CAR_PER);

    rx_state_t               state;
    mode_t                   sel_lat;
    logic signed [ACC_W-1:0] acc;
    logic [XC_W-1:0]         xc;
    logic [CNT_W-1:0]        scnt;
    logic                    prev_pos;

    logic signed [7:0]       d;
    logic signed [7:0]       abs_d;
    logic                    pos;
    logic                    ref_hi;
    logic                    leave;
    logic                    sym_end;
    logic signed [ACC_W-1:0] term;
    logic signed [ACC_W-1:0] acc_nxt;
    logic [XC_W-1:0]         xc_nxt;
    logic                    dec_bit;

    assign d       = signed'({1'b0, sample_in}) - signed'(8'(MIDSCALE));
    assign abs_d   = d[7] ? -d : d;
    assign pos     = (sample_in >= SAMPLE_W'(MIDSCALE));
    assign ref_hi  = (scnt[PH_W-1:0] < PH_W'(CAR_PER / 2));
    assign leave   = (state == RX_RUN) && (!en || (sel != sel_lat));
    assign sym_end = (state == RX_RUN) && !leave && sample_valid && (scnt == CNT_W'(SPS - 1));
    assign busy    = (state == RX_RUN);

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        term = '0;
        unique case (sel_lat)
            MODE_ASK:   term = ACC_W'(abs_d);
            MODE_FSK:   term = '0;
            MODE_BPSK:  term = ref_hi ? ACC_W'(d) : ACC_W'(-d);
            MODE_SLICE: term = pos ? ACC_W'(1) : '0;
        endcase
    end

    assign acc_nxt = acc + term;
    assign xc_nxt  = xc + XC_W'(pos != prev_pos);

    // The decision includes the sample being accepted, hence the *_nxt values.
    always_comb begin
        dec_bit = 1'b0;
        unique case (sel_lat)
            MODE_ASK:   dec_bit = (acc_nxt >= ACC_W'(ASK_THR));
            MODE_FSK:   dec_bit = (xc_nxt >= XC_W'(FSK_XTHR));
            MODE_BPSK:  dec_bit = acc_nxt[ACC_W-1];
            MODE_SLICE: dec_bit = (acc_nxt > ACC_W'(SPS / 2));
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= RX_IDLE;
            sel_lat   <= MODE_ASK;
            acc       <= '0;
            xc        <= '0;
            scnt      <= '0;
            prev_pos  <= 1'b0;
            bit_out   <= 1'b0;
            bit_valid <= 1'b0;
        end else begin
            bit_valid <= 1'b0;
            unique case (state)
                RX_IDLE: begin
                    if (en) begin
                        state   <= RX_RUN;
                        sel_lat <= mode_t'(sel);
                        acc     <= '0;
                        xc      <= '0;
                        scnt    <= '0;
                    end
                end
                RX_RUN: begin
                    if (leave) begin
                        // Disable or mode change: the partial symbol is dropped.
                        state <= RX_IDLE;
                        acc   <= '0;
                        xc    <= '0;
                        scnt  <= '0;
                    end else if (sample_valid) begin
                        prev_pos <= pos;
                        if (sym_end) begin
                            bit_out   <= dec_bit;
                            bit_valid <= 1'b1;
                            acc       <= '0;
                            xc        <= '0;
                            scnt      <= '0;
                        end else begin
                            acc  <= acc_nxt;
                            xc   <= xc_nxt;
                            scnt <= scnt + CNT_W'(1);
                        end
                    end
                end
            endcase
        end
    end

`ifdef MODEM_RX_BYTE_EN
    modem_byte_asm u_byte_asm (
        .clk        (clk),
        .reset      (reset),
        .clear      (leave),
        .shift      (sym_end),
        .bit_in     (dec_bit),
        .byte_out   (byte_out),
        .byte_valid (byte_valid)
    );
`else
    assign byte_out   = 8'h00;
    assign byte_valid = 1'b0;
`endif

endmodule

// File: tb/tb_modem_rx_demod.sv
// Self-checking bench for modem_rx_demod: directed cases plus randomized symbols
// compared against a symbol-level reference model.
module tb_modem_rx_demod;
    import modem_pkg::*;

    localparam int SPS      = 16;
    localparam int CAR_PER  = 8;
    localparam int ASK_THR  = 256;
    localparam int FSK_XTHR = 6;

    logic       clk = 1'b0;
    logic       reset;
    logic [1:0] sel;
    logic       en;
    logic [6:0] sample_in;
    logic       sample_valid;
    logic       bit_out;
    logic       bit_valid;
    logic [7:0] byte_out;
    logic       byte_valid;
    logic       busy;

    modem_rx_demod #(
        .SPS      (SPS),
        .CAR_PER  (CAR_PER),
        .ASK_THR  (ASK_THR),
        .FSK_XTHR (FSK_XTHR)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .sel          (sel),
        .en           (en),
        .sample_in    (sample_in),
        .sample_valid (sample_valid),
        .bit_out      (bit_out),
        .bit_valid    (bit_valid),
        .byte_out     (byte_out),
        .byte_valid   (byte_valid),
        .busy         (busy)
    );

    always #5 clk = ~clk;

    int   errors = 0;
    int   checks = 0;
    int   bv_count = 0;
    int   byv_count = 0;
    logic model_prev;
    logic last_byv;
    logic [7:0] last_byte;
    int   pat [SPS];

    always @(negedge clk) begin
        if (bit_valid === 1'b1)  bv_count++;
        if (byte_valid === 1'b1) byv_count++;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, want %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_cycles(input int n);
        sample_valid = 1'b0;
        repeat (n) step();
    endtask

    // A mode change aborts (one cycle) and re-enters RUN (one cycle).
    task automatic set_mode(input logic [1:0] m);
        sel = m;
        idle_cycles(2);
    endtask

    // Symbol-level reference: decisions from whole-symbol sums and counts.
    function automatic logic ref_bit(input logic [1:0] m, input int s [SPS], input logic p0);
        int   sum = 0;
        int   cnt = 0;
        logic p   = p0;
        case (m)
            MODE_ASK: begin
                foreach (s[i]) sum += (s[i] >= 64) ? s[i] - 64 : 64 - s[i];
                return sum >= ASK_THR;
            end
            MODE_FSK: begin
                foreach (s[i]) begin
                    if ((s[i] >= 64) != p) cnt++;
                    p = (s[i] >= 64);
                end
                return cnt >= FSK_XTHR;
            end
            MODE_BPSK: begin
                foreach (s[i]) sum += ((i % CAR_PER) < CAR_PER / 2) ? s[i] - 64 : 64 - s[i];
                return sum < 0;
            end
            default: begin
                foreach (s[i]) cnt += (s[i] >= 64) ? 1 : 0;
                return cnt > SPS / 2;
            end
        endcase
    endfunction

    task automatic send_symbol(input string tag, input bit gaps);
        int   bv0;
        logic exp_bit;
        exp_bit = ref_bit(sel, pat, model_prev);
        bv0     = bv_count;
        for (int i = 0; i < SPS; i++) begin
            if (gaps && $urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)));
            sample_in    = 7'(pat[i]);
            sample_valid = 1'b1;
            step();
            model_prev = (pat[i] >= 64);
        end
        sample_valid = 1'b0;
        last_byv  = byte_valid;
        last_byte = byte_out;
        check({tag, " bit_valid"}, 32'(bit_valid), 1);
        check({tag, " bit_out"}, 32'(bit_out), 32'(exp_bit));
        check({tag, " early strobes"}, 32'(bv_count - bv0), 0);
        step();
        check({tag, " strobe width"}, 32'(bit_valid), 0);
        check({tag, " bit hold"}, 32'(bit_out), 32'(exp_bit));
    endtask

    initial begin
        int bv0;
        reset = 1'b1; en = 1'b0; sel = MODE_ASK; sample_valid = 1'b0; sample_in = 7'd64;
        model_prev = 1'b0; last_byv = 1'b0; last_byte = 8'h00;
        repeat (2) step();
        check("reset busy", 32'(busy), 0);
        check("reset bit_valid", 32'(bit_valid), 0);
        check("reset bit_out", 32'(bit_out), 0);
        check("reset byte_valid", 32'(byte_valid), 0);
        check("reset byte_out", 32'(byte_out), 0);
        reset = 1'b0;
        step();
        check("idle busy", 32'(busy), 0);
        en = 1'b1;
        step();
        check("busy rise", 32'(busy), 1);

        foreach (pat[i]) pat[i] = 64;
        send_symbol("ask const", 0);
        foreach (pat[i]) pat[i] = (i % 2 == 0) ? 96 : 32;
        send_symbol("ask alt", 0);

        set_mode(MODE_FSK);
        foreach (pat[i]) pat[i] = (i % 8 < 4) ? 96 : 32;
        send_symbol("fsk p8", 0);
        foreach (pat[i]) pat[i] = (i % 4 < 2) ? 96 : 32;
        send_symbol("fsk p4 gaps", 1);
        foreach (pat[i]) pat[i] = (i % 8 < 4) ? 96 : 32;
        send_symbol("fsk p8 gaps", 1);

        set_mode(MODE_BPSK);
        foreach (pat[i]) pat[i] = (i % 8 < 4) ? 96 : 32;
        send_symbol("bpsk in-phase", 0);
        foreach (pat[i]) pat[i] = (i % 8 < 4) ? 32 : 96;
        send_symbol("bpsk inverted", 0);

        set_mode(MODE_SLICE);
        foreach (pat[i]) pat[i] = (i < 9) ? 100 : 20;
        send_symbol("slice 9/7", 0);
        foreach (pat[i]) pat[i] = (i < 8) ? 100 : 20;
        send_symbol("slice 8/8", 0);

        // Abort by mode change at scnt = 10.
        set_mode(MODE_ASK);
        bv0 = bv_count;
        for (int i = 0; i < 10; i++) begin
            sample_in = (i % 2 == 0) ? 7'd96 : 7'd32;
            sample_valid = 1'b1;
            step();
            model_prev = (i % 2 == 0);
        end
        sel = MODE_FSK;
        sample_in = 7'd96;
        step();
        check("abort busy low", 32'(busy), 0);
        check("abort bit_valid", 32'(bit_valid), 0);
        sample_valid = 1'b0;
        step();
        check("abort busy back", 32'(busy), 1);
        check("abort no strobe", 32'(bv_count - bv0), 0);
        foreach (pat[i]) pat[i] = (i % 4 < 2) ? 96 : 32;
        send_symbol("after abort fsk", 0);

        // en falls together with the final sample.
        bv0 = bv_count;
        for (int i = 0; i < SPS - 1; i++) begin
            sample_in = 7'(pat[i]);
            sample_valid = 1'b1;
            step();
            model_prev = (pat[i] >= 64);
        end
        en = 1'b0;
        sample_in = 7'(pat[SPS-1]);
        step();
        check("en fall bit_valid", 32'(bit_valid), 0);
        check("en fall busy", 32'(busy), 0);
        sample_valid = 1'b0;
        step();
        check("en fall no strobe", 32'(bv_count - bv0), 0);
        en = 1'b1;
        step();

        // Byte assembly: 1,0,1,0,0,1,0,1 -> 8'hA5.
        set_mode(MODE_ASK);
        for (int k = 0; k < 8; k++) begin
            logic [7:0] b;
            b = 8'hA5;
            foreach (pat[i]) pat[i] = b[7-k] ? ((i % 2 == 0) ? 96 : 32) : 64;
            send_symbol("byte bit", 0);
`ifdef MODEM_RX_BYTE_EN
            check("byte strobe", 32'(last_byv), (k == 7) ? 1 : 0);
`else
            check("byte strobe absent", 32'(last_byv), 0);
`endif
        end
`ifdef MODEM_RX_BYTE_EN
        check("byte value", 32'(last_byte), 32'h A5);
`else
        check("byte value absent", 32'(last_byte), 0);
`endif

        // Reset mid-symbol (bit_out is 1 from the last byte bit).
        for (int i = 0; i < 5; i++) begin
            sample_in = 7'd96;
            sample_valid = 1'b1;
            step();
        end
        reset = 1'b1;
        step();
        check("mid reset busy", 32'(busy), 0);
        check("mid reset bit_out", 32'(bit_out), 0);
        check("mid reset bit_valid", 32'(bit_valid), 0);
        check("mid reset byte_out", 32'(byte_out), 0);
        check("mid reset byte_valid", 32'(byte_valid), 0);
        model_prev = 1'b0;
        reset = 1'b0;
        sample_valid = 1'b0;
        step();
        foreach (pat[i]) pat[i] = (i % 2 == 0) ? 96 : 32;
        send_symbol("after reset ask", 0);

        // Randomized symbols across all modes.
        for (int n = 0; n < 40; n++) begin
            int amp;
            set_mode(2'($urandom_range(0, 3)));
            amp = int'($urandom_range(0, 63));
            foreach (pat[i]) pat[i] = 64 + int'($urandom_range(0, 2 * amp)) - amp;
            send_symbol("random", 1'($urandom_range(0, 1)));
        end

`ifndef MODEM_RX_BYTE_EN
        check("byte_valid never", 32'(byv_count), 0);
        check("byte_out constant", 32'(byte_out), 0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/modem_rx_demod.md
# modem_rx_demod

Multimode receive demodulator: the receive-side counterpart of the modem's modulator. It takes the 7-bit unsigned sample stream, centred on midscale 64, that the modulator drives onto its DAC pins. Each symbol period it makes a decision in one of four selectable modes and emits one recovered bit. Optionally it packs the bits into bytes. It sits between the sample input pins and the top-level wrapper, and uses the same `sel` mode encoding as the modulator.

## Interface
- `SPS`, 16: samples per symbol; power of two, 4..64
- `CAR_PER`, 8: BPSK reference carrier period in samples; even, divides `SPS`
- `ASK_THR`, 256: ASK energy threshold
- `FSK_XTHR`, 6: FSK zero-crossing threshold
- `clk` in 1: the block's single clock
- `reset` in 1: synchronous, active-high reset
- `sel` in 2: mode; 00 ASK, 01 FSK, 10 BPSK, 11 majority slicer
- `en` in 1: demodulator enable
- `sample_in` in 7: unsigned sample; 64 = zero level
- `sample_valid` in 1: `sample_in` is accepted this cycle
- `bit_out` in/out: out 1, recovered bit
- `bit_valid` out 1: one-cycle strobe, `bit_out` is new
- `byte_out` out 8: assembled byte, first bit received in the MSB
- `byte_valid` out 1: one-cycle strobe
- `busy` out 1: high while in the RUN state

## Operation
- FSM has two states, IDLE and RUN.
  - IDLE to RUN when `en` = 1.
  - RUN to IDLE when `en` = 0, or when `sel` differs from the `sel` latched at symbol start.
  - A `sel` change aborts the symbol: no `bit_valid`, accumulators cleared. The next cycle re-enters RUN if `en` = 1.
- In RUN, each accepted sample increments `scnt` (0..SPS-1). Define `d = sample_in - 64` (signed, 8 bits) and `pos = (sample_in >= 64)`.
- Per-mode accumulation:
  - ASK: `acc += |d|` (|d| max 64). Bit = `acc >= ASK_THR`.
  - FSK: `xc += 1` when `pos` differs from `prev_pos`. Bit = `xc >= FSK_XTHR`.
    - `prev_pos` updates on every accepted sample and persists across symbols.
    - `prev_pos` resets to 0.
  - BPSK: `ref = ((scnt mod CAR_PER) < CAR_PER/2)`. `acc += ref ? d : -d`. Bit = `acc < 0`.
  - Slicer: `acc += pos`. Bit = `acc > SPS/2`.
- Width rules:
  - `acc` is signed, `$clog2(64*SPS)+2` bits; cannot overflow.
  - `xc` is `$clog2(SPS)+1` bits.
- Symbol end: the accepted sample with `scnt == SPS-1`.
  - The decision includes that sample.
  - The decision registers `bit_out` and pulses `bit_valid`.
  - `acc`, `xc` and `scnt` clear the same cycle.
- Cycles with `sample_valid` = 0 freeze all state; the symbol simply stretches.
- Byte assembly (when compiled in):
  - Each `bit_valid` shifts `bit_out` into `sreg` and increments `bcnt`.
  - At `bcnt` wrap 7→0, `byte_out <= {sreg[6:0], bit}` and `byte_valid` pulses.
  - Leaving RUN (disable or abort) clears `bcnt` and `sreg`.
- Reset clears everything: state IDLE, all outputs 0, counters 0, `prev_pos` = 0.

## Timing
- `bit_valid` is high exactly one cycle, the cycle after the clock edge that accepts the final sample of the symbol.
- `byte_valid` is coincident with the `bit_valid` of the 8th bit. `byte_out` is valid that cycle and holds until the next byte.
- `bit_out` holds its value between strobes.
- `busy` goes high the cycle after `en` rises, and low the cycle after `en` falls or an abort.
- `en` falling at the final sample: that sample is not accepted and no bit is emitted.
- Simultaneous `reset` and any input: reset wins.
- Minimum bit interval: `SPS` cycles.

## Configuration
- Macro: `MODEM_RX_BYTE_EN`.
- Defined: byte assembler present, with `byte_out`/`byte_valid` as described.
- Undefined: no assembler logic; `byte_out` = 8'h00 and `byte_valid` = 0 constant. Ports remain.

## Structure
- Package `modem_pkg` holds:
  - mode typedef (`MODE_ASK`, `MODE_FSK`, `MODE_BPSK`, `MODE_SLICE`), shared with the modulator;
  - the midscale constant 64;
  - the sample width 7.
- One sub-module: `modem_byte_asm`, the shift register, bit counter and byte strobe, instantiated under the macro.

## Test plan
- ASK, SPS = 16:
  - constant 64 → `acc` 0 → `bit_out` 0;
  - alternating 96/32 → `acc` 512 → `bit_out` 1.
  - Each symbol gives one `bit_valid` exactly 1 cycle after the 16th sample.
- FSK:
  - square wave 96/32, period 8 → ≤4 crossings → 0;
  - period 4 → ≥7 crossings → 1;
  - gaps in `sample_valid` do not change the result.
- BPSK, CAR_PER = 8:
  - 96 for `scnt mod 8 < 4`, else 32 → `acc` +512 → 0;
  - inverted phase → `acc` −512 → 1.
- Slicer with 9 samples at 100 and 7 at 20 → 1; 8/8 → 0.
- Abort and reset:
  - change `sel` at `scnt` = 10 → no strobe, `busy` drops for one cycle, next symbol decodes correctly;
  - `reset` mid-symbol → all outputs 0 next cycle.
- Bytes (`MODEM_RX_BYTE_EN` defined): ASK bits 1,0,1,0,0,1,0,1 → `byte_out` 8'hA5 with `byte_valid` coincident with the 8th `bit_valid`. Macro undefined → `byte_valid` never asserts.
